pipeline_stall_sequencer: RTL and testbench

- Central stall/flush/halt controller for the 5-stage pipelined RV32I core.
- Merges four conditions into one set of pipeline-register write enables and flush strobes: load-use hazard, data-memory busy, EX-stage branch mispredict, and ecall halt.
- Sequences the halt drain through a small FSM.
- Sits beside the hazard detector and forwarding unit; drives PC, IF/ID, ID/EX and EX/MEM control.

---
 rtl/pipeline_stall_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_sequencer.sv
// rtl/pipeline_stall_sequencer.sv - stall/flush/halt controller for the 5-stage RV32I pipeline
//
// Purpose: merges load-use, data-memory busy, EX mispredict and ecall halt
// into pipeline-register write enables and flush strobes, and walks the
// halt drain through a RUN -> DRAIN -> HALTED state machine.
//
// Optional feature macro: STALL_SEQ_PERF_CNT_EN
//   defined   : stall_cnt / flush_cnt are saturating performance counters
//   undefined : both ports are tied to 0 and no counter flops exist
//
// Ports:
//   clk, reset          core clock (rising edge), async active-low reset
//   rs1, rs2            ID-stage source registers
//   use_rs1, use_rs2    ID instruction actually reads rs1 / rs2
//   ID_EX_rd            destination register of the instruction in EX
//   ID_EX_mem_read      instruction in EX is a load
//   mem_busy            data memory not ready this cycle
//   mispredict          EX-stage branch/jump resolved against prediction
//   halt_req            ID instruction is ecall with x17==10
//   PCWrite             PC write enable
//   IF_IDWrite          IF/ID write enable
//   ID_EX_Write         ID/EX write enable
//   EX_MEM_Write        EX/MEM and MEM/WB write enable
//   IF_ID_flush         zero IF/ID on the next edge
//   ID_EX_bubble        load a NOP into ID/EX on the next edge
//   is_halted           core halted (registered, sticky until reset)
//   stall_cnt           cycles stalled by load-use or mem_busy
//   flush_cnt           mispredict flush events

module pipeline_stall_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_mem_read,
  input  logic             mem_busy,
  input  logic             mispredict,
  input  logic             halt_req,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] drain_ctr_q, drain_ctr_d;
  logic       is_halted_q, is_halted_d;

  logic       lu;
  logic       stall_ev;
  logic       flush_ev;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
              (((rs1 == ID_EX_rd) && use_rs1) || ((rs2 == ID_EX_rd) && use_rs2));

  always_comb begin
    state_d      = state_q;
    drain_ctr_d  = drain_ctr_q;
    PCWrite      = 1'b0;
    IF_IDWrite   = 1'b0;
    ID_EX_Write  = 1'b0;
    EX_MEM_Write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          // Full freeze: everything else waits for memory.
          stall_ev = 1'b1;
        end else if (mispredict) begin
          // ID instruction is wrong-path, so its lu/halt is dropped.
          PCWrite      = 1'b1;
          IF_IDWrite   = 1'b1;
          ID_EX_Write  = 1'b1;
          EX_MEM_Write = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
          flush_ev     = 1'b1;
        end else if (lu) begin
          ID_EX_Write  = 1'b1;
          EX_MEM_Write = 1'b1;
          ID_EX_bubble = 1'b1;
          stall_ev     = 1'b1;
        end else if (halt_req) begin
          // The ecall itself moves into EX; fetch stops behind it.
          ID_EX_Write  = 1'b1;
          EX_MEM_Write = 1'b1;
          state_d      = ST_DRAIN;
          drain_ctr_d  = 4'(DRAIN_CYCLES);
        end else begin
          PCWrite      = 1'b1;
          IF_IDWrite   = 1'b1;
          ID_EX_Write  = 1'b1;
          EX_MEM_Write = 1'b1;
        end
      end

      ST_DRAIN: begin
        ID_EX_bubble = 1'b1;
        ID_EX_Write  = !mem_busy;
        EX_MEM_Write = !mem_busy;
        if (mem_busy) begin
          stall_ev = 1'b1;
        end else if (drain_ctr_q <= 4'd1) begin
          drain_ctr_d = 4'd0;
          state_d     = ST_HALTED;
        end else begin
          drain_ctr_d = drain_ctr_q - 4'd1;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d     = ST_RUN;
        drain_ctr_d = 4'd0;
      end
    endcase

    is_halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_ctr_q <= 4'd0;
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_ctr_q <= drain_ctr_d;
      is_halted_q <= is_halted_d;
    end
  end

  assign is_halted = is_halted_q;

`ifdef STALL_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = stall_ev ^ flush_ev;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb/tb_pipeline_stall_sequencer.sv - self-checking bench for pipeline_stall_sequencer

module tb_pipeline_stall_sequencer;

  localparam int DRAIN = 3;
  localparam int CW    = 4;
  localparam int SAT   = 15;
`ifdef STALL_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs1, rs2, ID_EX_rd;
  logic use_rs1, use_rs2, ID_EX_mem_read, mem_busy, mispredict, halt_req;
  logic PCWrite, IF_IDWrite, ID_EX_Write, EX_MEM_Write, IF_ID_flush, ID_EX_bubble, is_halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read), .mem_busy(mem_busy),
    .mispredict(mispredict), .halt_req(halt_req), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .is_halted(is_halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, memrd, busy, mis, halt;
  } in_t;

  typedef struct {
    in_t        i;
    logic [5:0] exp; // {PCWrite, IF_IDWrite, ID_EX_Write, EX_MEM_Write, IF_ID_flush, ID_EX_bubble}
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the core is either running, draining with a number of
  // free cycles still owed, or halted.
  bit m_halted;
  int m_drain_left;
  int m_stall, m_flush;
  bit last_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t i;
    i = '0;
    return i;
  endfunction

  function automatic bit load_use(input in_t i);
    return i.memrd && i.rd != 0 && ((i.rs1 == i.rd && i.use1) || (i.rs2 == i.rd && i.use2));
  endfunction

  function automatic logic [5:0] model_outs(input in_t i);
    if (m_halted) return 6'b0000_00;
    if (m_drain_left > 0) return {2'b00, !i.busy, !i.busy, 2'b01};
    if (i.busy) return 6'b0000_00;
    if (i.mis) return 6'b1111_11;
    if (load_use(i)) return 6'b0011_01;
    if (i.halt) return 6'b0011_00;
    return 6'b1111_00;
  endfunction

  task automatic model_step(input in_t i);
    if (m_halted) return;
    if (m_drain_left > 0) begin
      if (i.busy) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      else begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1'b1;
      end
    end else if (i.busy) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    else if (i.mis) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
    else if (load_use(i)) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    else if (i.halt) m_drain_left = DRAIN;
  endtask

  task automatic model_reset();
    m_halted = 1'b0;
    m_drain_left = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic drive(input in_t i);
    rs1 = i.rs1; rs2 = i.rs2; ID_EX_rd = i.rd;
    use_rs1 = i.use1; use_rs2 = i.use2; ID_EX_mem_read = i.memrd;
    mem_busy = i.busy; mispredict = i.mis; halt_req = i.halt;
  endtask

  // Called just after a falling edge; checks mid-cycle, then advances one cycle.
  task automatic step(input in_t i, input string name);
    logic [5:0] act;
    drive(i);
    #1;
    act = {PCWrite, IF_IDWrite, ID_EX_Write, EX_MEM_Write, IF_ID_flush, ID_EX_bubble};
    chk({name, " ctrl"}, {26'd0, act}, {26'd0, model_outs(i)});
    chk({name, " state"}, {22'd0, is_halted, 1'b0, stall_cnt, 1'b0, flush_cnt},
        {22'd0, m_halted, 1'b0, PERF ? 4'(m_stall) : 4'd0, 1'b0, PERF ? 4'(m_flush) : 4'd0});
    last_halted = is_halted;
    model_step(i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(idle());
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    in_t v;
    int first;

    // rs1, rs2, rd, use1, use2, memrd, busy, mis, halt
    tbl[0] = '{'{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 6'b1111_00};
    tbl[1] = '{'{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 6'b0011_01};
    tbl[2] = '{'{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 6'b1111_00};
    tbl[3] = '{'{5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 6'b0011_01};
    tbl[4] = '{'{5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 6'b1111_00};
    tbl[5] = '{'{5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 6'b1111_00};
    tbl[6] = '{'{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 6'b1111_11};
    tbl[7] = '{'{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}, 6'b0000_00};
    tbl[8] = '{'{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}, 6'b1111_11};

    drive(idle());
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset is_halted", {31'd0, is_halted}, 32'd0);
    chk("reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("reset flush_cnt", {28'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table vectors: all stay in RUN (halt is always masked by something higher).
    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #1;
      chk($sformatf("table[%0d]", k),
          {26'd0, PCWrite, IF_IDWrite, ID_EX_Write, EX_MEM_Write, IF_ID_flush, ID_EX_bubble},
          {26'd0, tbl[k].exp});
      @(negedge clk);
      model_step(tbl[k].i);
    end
    // lu x2, busy x1 -> 3 stalls; mispredict x2 -> 2 flushes
    chk("table stall_cnt", {28'd0, stall_cnt}, PERF ? 32'd3 : 32'd0);
    chk("table flush_cnt", {28'd0, flush_cnt}, PERF ? 32'd2 : 32'd0);

    // Load-use then rd=x0.
    do_reset();
    v = idle(); v.memrd = 1; v.rd = 5; v.rs1 = 5; v.use1 = 1;
    step(v, "lu");
    v.rd = 0; v.rs1 = 0;
    step(v, "lu_x0");
    chk("lu stall_cnt", {28'd0, stall_cnt}, PERF ? 32'd1 : 32'd0);

    // mem_busy x3 with mispredict, flush lands after busy drops.
    do_reset();
    v = idle(); v.busy = 1; v.mis = 1;
    repeat (3) step(v, "busy_mis");
    chk("busy flush_cnt", {28'd0, flush_cnt}, 32'd0);
    chk("busy stall_cnt", {28'd0, stall_cnt}, PERF ? 32'd3 : 32'd0);
    v.busy = 0;
    drive(v);
    #1;
    chk("post-busy flush", {31'd0, IF_ID_flush}, 32'd1);
    @(negedge clk);
    chk("post-busy flush_cnt", {28'd0, flush_cnt}, PERF ? 32'd1 : 32'd0);
    model_step(v);

    // Halt drain without busy: is_halted on 4th cycle after request.
    do_reset();
    v = idle(); v.halt = 1;
    step(v, "halt_req");
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step(idle(), "drain");
      if (last_halted && first < 0) first = k;
    end
    chk("halt latency", first, 32'd4);

    // Halt drain with two busy cycles mid-drain.
    do_reset();
    step(v, "halt_req2");
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      in_t d;
      d = idle();
      d.busy = (k == 2 || k == 3);
      d.halt = 1; d.mis = 1;
      step(d, "drain_busy");
      if (last_halted && first < 0) first = k;
    end
    chk("halt latency busy", first, 32'd6);

    // Asynchronous reset mid-drain.
    do_reset();
    step(v, "halt_req3");
    v = idle(); v.busy = 1;
    step(v, "drain_busy3");
    drive(idle());
    #3 reset = 1'b0;
    #1;
    chk("async is_halted", {31'd0, is_halted}, 32'd0);
    chk("async stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("async PCWrite", {31'd0, PCWrite}, 32'd1);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    step(idle(), "after_async");
    chk("after async is_halted", {31'd0, is_halted}, 32'd0);

    // Counter saturation.
    do_reset();
    v = idle(); v.memrd = 1; v.rd = 9; v.rs2 = 9; v.use2 = 1;
    repeat (20) step(v, "sat");
    chk("stall saturation", {28'd0, stall_cnt}, PERF ? 32'd15 : 32'd0);

    // Randomized run against the model.
    do_reset();
    begin
      int halted_for;
      halted_for = 0;
      for (int n = 0; n < 1500; n++) begin
        in_t r;
        r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
        r.rd = 5'($urandom_range(0, 3));
        r.use1 = 1'($urandom); r.use2 = 1'($urandom); r.memrd = 1'($urandom);
        r.busy = ($urandom_range(0, 4) == 0);
        r.mis  = ($urandom_range(0, 7) == 0);
        r.halt = ($urandom_range(0, 19) == 0);
        step(r, "rand");
        halted_for = m_halted ? halted_for + 1 : 0;
        if (halted_for > 3) begin
          do_reset();
          halted_for = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
